comma_aligner: RTL and testbench

COMMA_ALIGNER -- requirements
Module: comma_aligner

---
 rtl/rx_pkg.sv | 28 ++
 rtl/comma_finder.sv | 23 ++
 rtl/comma_aligner.sv | 147 ++++++++++++++
 tb/tb_comma_aligner.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared symbol constants, aligner state encoding and small symbol helpers
// for the receive path.
package rx_pkg;

    localparam int SYMBOL_WIDTH = 10;

    localparam logic [SYMBOL_WIDTH-1:0] K28_5_RDN = 10'h17C;
    localparam logic [SYMBOL_WIDTH-1:0] K28_5_RDP = 10'h283;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } align_state_e;

    function automatic logic is_comma(input logic [SYMBOL_WIDTH-1:0] sym);
        return (sym == K28_5_RDN) || (sym == K28_5_RDP);
    endfunction

    // Candidate k of a two-word window is bits [k+9:k].
    function automatic logic [SYMBOL_WIDTH-1:0] pick_symbol(
        input logic [2*SYMBOL_WIDTH-1:0] window,
        input logic [3:0]                k
    );
        return SYMBOL_WIDTH'(window >> k);
    endfunction

endpackage

// File: rtl/comma_finder.sv
// Combinational search for a K28.5 comma across all ten bit offsets of a
// two-word window; the lowest matching offset is reported.
module comma_finder
    import rx_pkg::*;
(
    input  logic [2*SYMBOL_WIDTH-1:0] window_i,
    output logic                      found_o,
    output logic [3:0]                offset_o
);

    // Scanning downwards lets the lowest matching offset overwrite the others.
    always_comb begin
        found_o  = 1'b0;
        offset_o = 4'd0;
        for (int k = SYMBOL_WIDTH - 1; k >= 0; k--) begin
            if (is_comma(pick_symbol(window_i, 4'(k)))) begin
                found_o  = 1'b1;
                offset_o = 4'(k);
            end
        end
    end

endmodule

// File: rtl/comma_aligner.sv
// 8b/10b symbol aligner: finds K28.5 in the raw deserializer stream, locks to a
// bit offset after repeated agreement and emits aligned symbols one cycle later.
module comma_aligner
    import rx_pkg::*;
#(
    parameter int LOCK_COUNT   = 3,
    parameter int UNLOCK_COUNT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SYMBOL_WIDTH-1:0] data_in,
    input  logic                    data_in_valid,
    output logic [SYMBOL_WIDTH-1:0] data_out,
    output logic                    data_out_valid,
    output logic                    comma_detect,
    output logic                    locked,
    output logic [3:0]              offset
);

    localparam logic [3:0] LOCK_C   = 4'(LOCK_COUNT);
    localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_COUNT);

    align_state_e            state_q, state_d;
    logic [SYMBOL_WIDTH-1:0] prev_q, prev_d;
    logic                    full_q, full_d;
    logic [3:0]              cand_q, cand_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [3:0]              mis_q, mis_d;
    logic [3:0]              off_q, off_d;
    logic [SYMBOL_WIDTH-1:0] dout_q, dout_d;
    logic                    dv_q, dv_d;
    logic                    cd_q, cd_d;
    logic                    lk_q, lk_d;

    logic [2*SYMBOL_WIDTH-1:0] window;
    logic                      found;
    logic [3:0]                found_off;
    logic [3:0]                cnt_inc;
    logic [3:0]                mis_inc;

    assign window  = {data_in, prev_q};
    assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    assign mis_inc = (mis_q == 4'hF) ? mis_q : mis_q + 4'd1;

    comma_finder u_finder (
        .window_i (window),
        .found_o  (found),
        .offset_o (found_off)
    );

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        full_d  = full_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        off_d   = off_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;
        cd_d    = 1'b0;

        if (data_in_valid) begin
            prev_d = data_in;
            full_d = 1'b1;
            if (full_q) begin
                case (state_q)
                    SEARCH: begin
                        if (found) begin
                            cand_d  = found_off;
                            cnt_d   = 4'd1;
                            state_d = CHECK;
                        end
                    end
                    CHECK: begin
                        if (found && (found_off == cand_q)) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc >= LOCK_C) begin
                                state_d = LOCKED;
                                off_d   = cand_q;
                                mis_d   = 4'd0;
                            end
                        end else if (found) begin
                            cand_d = found_off;
                            cnt_d  = 4'd1;
                        end
                    end
                    LOCKED: begin
                        // A comma at the locked offset wins even if a lower one also matches.
                        if (is_comma(pick_symbol(window, off_q))) begin
                            mis_d = 4'd0;
                        end else if (found) begin
                            mis_d = mis_inc;
                            if (mis_inc >= UNLOCK_C) begin
                                state_d = SEARCH;
                            end
                        end
                    end
                    default: state_d = SEARCH;
                endcase
            end

            if (state_d == LOCKED) begin
                dout_d = pick_symbol(window, off_d);
                dv_d   = 1'b1;
                cd_d   = is_comma(pick_symbol(window, off_d));
            end
        end

        lk_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEARCH;
            prev_q  <= '0;
            full_q  <= 1'b0;
            cand_q  <= 4'd0;
            cnt_q   <= 4'd0;
            mis_q   <= 4'd0;
            off_q   <= 4'd0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            cd_q    <= 1'b0;
            lk_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            full_q  <= full_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            off_q   <= off_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            cd_q    <= cd_d;
            lk_q    <= lk_d;
        end
    end

    assign data_out       = dout_q;
    assign data_out_valid = dv_q;
    assign comma_detect   = cd_q;
    assign locked         = lk_q;
    assign offset         = off_q;

endmodule

// File: tb/tb_comma_aligner.sv
// Directed bench for comma_aligner: bit-shifted comma streams with a reference
// aligner model feeding an expected-output queue.
module tb_comma_aligner;

    localparam int M_SEARCH = 0;
    localparam int M_CHECK  = 1;
    localparam int M_LOCKED = 2;
    localparam logic [9:0] FILL = 10'h2AA;
    localparam logic [9:0] KN   = 10'h17C;
    localparam logic [9:0] KP   = 10'h283;

    logic       clk;
    logic       rst_n;
    logic [9:0] data_in;
    logic       data_in_valid;
    logic [9:0] data_out;
    logic       data_out_valid;
    logic       comma_detect;
    logic       locked;
    logic [3:0] offset;

    comma_aligner #(.LOCK_COUNT(3), .UNLOCK_COUNT(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .comma_detect   (comma_detect),
        .locked         (locked),
        .offset         (offset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] dout;
        logic       dv;
        logic       cd;
        logic       lk;
        logic [3:0] off;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    // reference model state
    int         m_state, m_cand, m_cnt, m_mis, m_off;
    logic [9:0] m_prev, m_dout;
    logic       m_full, m_dv, m_cd;
    logic [9:0] last_sym;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_comma(input logic [9:0] s);
        return (s == KN) || (s == KP);
    endfunction

    task automatic model_reset();
        m_state = M_SEARCH; m_cand = 0; m_cnt = 0; m_mis = 0; m_off = 0;
        m_prev = '0; m_dout = '0; m_full = 1'b0; m_dv = 1'b0; m_cd = 1'b0;
    endtask

    task automatic model_step(input logic [9:0] w, input logic v);
        logic [19:0] win;
        logic        fnd;
        int          fk;
        exp_t        e;
        m_dv = 1'b0;
        m_cd = 1'b0;
        if (v) begin
            win = {w, m_prev};
            if (m_full) begin
                fnd = 1'b0;
                fk  = 0;
                for (int k = 0; k < 10; k++) begin
                    if (!fnd && ref_comma(10'(win >> k))) begin
                        fnd = 1'b1;
                        fk  = k;
                    end
                end
                if (m_state == M_SEARCH) begin
                    if (fnd) begin m_cand = fk; m_cnt = 1; m_state = M_CHECK; end
                end else if (m_state == M_CHECK) begin
                    if (fnd && fk == m_cand) begin
                        if (m_cnt < 15) m_cnt++;
                        if (m_cnt >= 3) begin m_state = M_LOCKED; m_off = m_cand; m_mis = 0; end
                    end else if (fnd) begin
                        m_cand = fk; m_cnt = 1;
                    end
                end else begin
                    if (ref_comma(10'(win >> m_off))) m_mis = 0;
                    else if (fnd) begin
                        if (m_mis < 15) m_mis++;
                        if (m_mis >= 4) m_state = M_SEARCH;
                    end
                end
            end
            m_prev = w;
            m_full = 1'b1;
            if (m_state == M_LOCKED) begin
                m_dout = 10'(win >> m_off);
                m_dv   = 1'b1;
                m_cd   = ref_comma(m_dout);
            end
        end
        e.dout = m_dout;
        e.dv   = m_dv;
        e.cd   = m_cd;
        e.lk   = (m_state == M_LOCKED);
        e.off  = 4'(m_off);
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [9:0] w, input logic v);
        exp_t e;
        data_in       = w;
        data_in_valid = v;
        model_step(w, v);
        @(posedge clk);
        #1;
        n_assert++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL sb_empty observed=0 expected=1");
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_valid", 16'(data_out_valid), 16'(e.dv));
            chk("sb_comma", 16'(comma_detect), 16'(e.cd));
            chk("sb_locked", 16'(locked), 16'(e.lk));
            chk("sb_offset", 16'(offset), 16'(e.off));
            if (e.dv) chk("sb_data", 16'(data_out), 16'(e.dout));
        end
    endtask

    // Emits one symbol into a bit stream delayed by k bits relative to word boundaries.
    task automatic send_sym(input logic [9:0] sym, input int k);
        logic [19:0] t;
        t = {sym, last_sym};
        last_sym = sym;
        send(10'(t >> (10 - k)), 1'b1);
    endtask

    task automatic group(input logic [9:0] sym, input int k);
        send_sym(sym, k);
        repeat (3) send_sym(FILL, k);
    endtask

    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_data", 16'(data_out), 16'h0);
        chk("rst_valid", 16'(data_out_valid), 16'h0);
        chk("rst_comma", 16'(comma_detect), 16'h0);
        chk("rst_locked", 16'(locked), 16'h0);
        chk("rst_offset", 16'(offset), 16'h0);
        model_reset();
        data_in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        data_in       = '0;
        data_in_valid = 1'b0;
        last_sym      = FILL;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("init_valid", 16'(data_out_valid), 16'h0);
        chk("init_locked", 16'(locked), 16'h0);
        chk("init_offset", 16'(offset), 16'h0);
        chk("init_data", 16'(data_out), 16'h0);
        rst_n = 1'b1;

        // Lock at offset 3; the locking comma is the first symbol out.
        group(KN, 3);
        group(KN, 3);
        chk("s1_prelock", 16'(locked), 16'h0);
        send_sym(KN, 3);
        send_sym(FILL, 3);
        chk("s1_locked", 16'(locked), 16'h1);
        chk("s1_offset", 16'(offset), 16'h3);
        chk("s1_first_valid", 16'(data_out_valid), 16'h1);
        chk("s1_first_data", 16'(data_out), 16'h17C);
        chk("s1_first_comma", 16'(comma_detect), 16'h1);
        send_sym(FILL, 3);
        chk("s1_fill_data", 16'(data_out), 16'h2AA);
        chk("s1_fill_comma", 16'(comma_detect), 16'h0);
        send_sym(FILL, 3);

        // Stream moves to offset 7: unlock on the 4th misaligned comma, relock after 3 more.
        repeat (3) group(KN, 7);
        chk("s2_still_locked", 16'(locked), 16'h1);
        send_sym(KN, 7);
        send_sym(FILL, 7);
        chk("s2_unlocked", 16'(locked), 16'h0);
        chk("s2_unlock_valid", 16'(data_out_valid), 16'h0);
        send_sym(FILL, 7);
        send_sym(FILL, 7);
        repeat (2) group(KN, 7);
        chk("s2_not_yet", 16'(locked), 16'h0);
        group(KN, 7);
        chk("s2_relocked", 16'(locked), 16'h1);
        chk("s2_offset", 16'(offset), 16'h7);

        // Reset while locked, then full reacquisition.
        do_reset();
        repeat (2) group(KN, 7);
        chk("s6_no_early_lock", 16'(locked), 16'h0);
        group(KN, 7);
        chk("s6_relock", 16'(locked), 16'h1);
        chk("s6_offset", 16'(offset), 16'h7);

        // Candidate change in CHECK restarts the count.
        do_reset();
        repeat (2) group(KN, 2);
        repeat (2) group(KN, 5);
        chk("s3_no_lock", 16'(locked), 16'h0);
        group(KN, 5);
        chk("s3_locked", 16'(locked), 16'h1);
        chk("s3_offset", 16'(offset), 16'h5);

        // Valid gap in CHECK must preserve count, state and the stored word.
        do_reset();
        group(KN, 4);
        send_sym(KN, 4);
        for (int i = 0; i < 5; i++) begin
            send(10'($urandom_range(0, 1023)), 1'b0);
            chk("s4_gap_valid", 16'(data_out_valid), 16'h0);
        end
        repeat (3) send_sym(FILL, 4);
        chk("s4_after_gap", 16'(locked), 16'h0);
        group(KN, 4);
        chk("s4_locked", 16'(locked), 16'h1);
        chk("s4_offset", 16'(offset), 16'h4);

        // Alternating disparity commas at offset 0.
        do_reset();
        send_sym(KN, 0);
        send_sym(KP, 0);
        send_sym(KN, 0);
        chk("s5_prelock", 16'(locked), 16'h0);
        send_sym(KP, 0);
        chk("s5_locked", 16'(locked), 16'h1);
        chk("s5_offset", 16'(offset), 16'h0);
        chk("s5_rdn_data", 16'(data_out), 16'h17C);
        chk("s5_rdn_comma", 16'(comma_detect), 16'h1);
        send_sym(KN, 0);
        chk("s5_rdp_data", 16'(data_out), 16'h283);
        chk("s5_rdp_comma", 16'(comma_detect), 16'h1);
        send_sym(FILL, 0);
        send_sym(FILL, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
